// File: rtl/write_back_reg_file_pkg.sv
`default_nettype none
// write_back_reg_file_pkg: shared widths and read-source encoding for the register file. Rev 1.0
package write_back_reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;
  localparam int NUM_REGS   = 32;
  localparam int COUNT_W    = 8;

  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic [1:0] {
    RD_REG  = 2'd0,
    RD_ZERO = 2'd1,
    RD_FWD  = 2'd2
  } rd_src_e;

endpackage
`default_nettype wire

// File: rtl/write_back_reg_file_if.sv
`default_nettype none
// write_back_reg_file_if: write-back port and two read ports of the register file. Rev 1.0
interface write_back_reg_file_if
  import write_back_reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  count_t            WriteCount;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2, WriteCount
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2, WriteCount
  );

endinterface
`default_nettype wire

// File: rtl/write_back_reg_file_decoder.sv
`default_nettype none
// Decoder5To32: enabled binary-to-one-hot decoder used to build the register write-enable vector. Rev 1.0
module Decoder5To32 #(
  parameter int ADDR_W = 5,
  parameter int OUT_W  = 1 << ADDR_W
) (
  input  wire logic              i_en,
  input  wire logic [ADDR_W-1:0] i_addr,
  output logic      [OUT_W-1:0]  o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot = OUT_W'(1) << i_addr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/write_back_reg_file.sv
`default_nettype none
// write_back_reg_file: 2R/1W register file with hardwired-zero r0, optional write-cycle forwarding
// and a committed-write counter. Rev 1.0
module write_back_reg_file
  import write_back_reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYPASS = 1
) (
  input wire logic            Clk,
  input wire logic            Reset,
  write_back_reg_file_if.slave bus
);

  localparam int                 c_DEPTH     = 1 << ADDR_W;
  localparam logic [c_DEPTH-1:0] c_ZERO_MASK = c_DEPTH'(1) << ZERO_REG;

  logic [DATA_W-1:0]  r_regs [c_DEPTH];
  count_t             r_write_count;

  logic [c_DEPTH-1:0] w_dec;
  logic [c_DEPTH-1:0] w_wr_en;
  logic               w_any_write;
  logic               w_fwd_en;
  rd_src_e            w_src1;
  rd_src_e            w_src2;

  Decoder5To32 #(
    .ADDR_W (ADDR_W),
    .OUT_W  (c_DEPTH)
  ) u_wr_dec (
    .i_en     (bus.RegWrite),
    .i_addr   (bus.WriteRegister),
    .o_onehot (w_dec)
  );

  // r0 never receives an enable, so it also never bumps the counter.
  assign w_wr_en     = w_dec & ~c_ZERO_MASK;
  assign w_any_write = |w_wr_en;

  generate
    if (BYPASS != 0) begin : g_bypass
      assign w_fwd_en = bus.RegWrite && !Reset &&
                        (bus.WriteRegister != ADDR_W'(ZERO_REG));
    end else begin : g_no_bypass
      assign w_fwd_en = 1'b0;
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_write_count <= '0;
    end else begin
      for (int i = 1; i < c_DEPTH; i++) begin
        if (w_wr_en[i]) begin
          r_regs[i] <= bus.WriteData;
        end
      end
      if (w_any_write) begin
        r_write_count <= r_write_count + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    w_src1 = RD_REG;
    if (bus.ReadRegister1 == ADDR_W'(ZERO_REG)) begin
      w_src1 = RD_ZERO;
    end else if (w_fwd_en && (bus.ReadRegister1 == bus.WriteRegister)) begin
      w_src1 = RD_FWD;
    end
  end

  always_comb begin
    w_src2 = RD_REG;
    if (bus.ReadRegister2 == ADDR_W'(ZERO_REG)) begin
      w_src2 = RD_ZERO;
    end else if (w_fwd_en && (bus.ReadRegister2 == bus.WriteRegister)) begin
      w_src2 = RD_FWD;
    end
  end

  always_comb begin
    bus.ReadData1 = r_regs[bus.ReadRegister1];
    case (w_src1)
      RD_ZERO: bus.ReadData1 = '0;
      RD_FWD:  bus.ReadData1 = bus.WriteData;
      default: bus.ReadData1 = r_regs[bus.ReadRegister1];
    endcase
  end

  always_comb begin
    bus.ReadData2 = r_regs[bus.ReadRegister2];
    case (w_src2)
      RD_ZERO: bus.ReadData2 = '0;
      RD_FWD:  bus.ReadData2 = bus.WriteData;
      default: bus.ReadData2 = r_regs[bus.ReadRegister2];
    endcase
  end

  assign bus.WriteCount = r_write_count;

endmodule
`default_nettype wire

// File: doc/write_back_reg_file.md
# write_back_reg_file

32 x 32-bit general-purpose register file for the single-cycle datapath, with one synchronous write port and two combinational read ports. The write port is the destination end of the datapath's write-back selection: the 32-bit value chosen for write-back enters here and is steered to exactly one register by a 5-to-32 one-hot write decoder. The two read ports feed the ALU operand path. Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 32, register and port data width.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- BYPASS, 1, 1 = write-to-read forwarding in the write cycle; 0 = reads return the pre-edge register contents.

Ports:
- Clk  in  1  clock; all register writes occur on the rising edge.
- Reset  in  1  asynchronous, active-high reset; clears all registers.
- RegWrite  in  1  write enable for the current cycle.
- WriteRegister  in  ADDR_W  destination register address.
- WriteData  in  DATA_W  write-back value.
- ReadRegister1  in  ADDR_W  read port 1 address.
- ReadRegister2  in  ADDR_W  read port 2 address.
- ReadData1  out  DATA_W  read port 1 data, combinational.
- ReadData2  out  DATA_W  read port 2 data, combinational.
- WriteCount  out  8  count of committed writes to non-zero registers; wraps at 255 -> 0.

## Operation
- Write decode: one-hot enable vector = RegWrite ? (1 << WriteRegister) : 0. Bit 0 of the vector is always forced to 0.
- Commit: on the rising edge, if the enable bit for register r is set, r <= WriteData. Exactly one register changes per edge at most.
- Writes to register 0 are discarded. They do not increment WriteCount.
- Read: ReadDataN = regs[ReadRegisterN]. Register 0 always reads 0.
- Bypass (BYPASS=1): if RegWrite=1, WriteRegister=ReadRegisterN, WriteRegister!=0, and Reset=0, then ReadDataN = WriteData in the same cycle. Both ports forward independently; both may forward simultaneously when both addresses match.
- Bypass is suppressed while Reset=1, so every read returns 0 during reset.
- WriteCount increments by 1 on each committed non-zero-register write and wraps mod 256.
- Reset: asynchronously clears all registers and WriteCount. Asserting Reset mid-cycle overrides any pending write; no write commits on an edge where Reset is high.

## Timing
- Write latency: the new value is visible on the read ports from the cycle after the write edge. With BYPASS=1 it is visible in the write cycle itself.
- Read latency: combinational, 0 cycles from address change.
- Reset values: ReadData1=0, ReadData2=0, WriteCount=0, all registers 0. These hold immediately on Reset assertion, without waiting for a clock.
- First write can commit on the first rising edge after Reset deasserts.
- Back-to-back writes to the same register: the last edge wins. There is no hazard interlock inside the block.

## Structure
- Shared package: DATA_W and ADDR_W defaults, ZERO_REG=0, NUM_REGS=32.
- Sub-module: Decoder5To32 (ADDR_W -> 2**ADDR_W one-hot, with enable input). This is the demultiplexing counterpart to the datapath's selection muxes and is reused for the write-enable vector.
- Register array, read muxing, bypass compare, and the counter live in the top module.

## Test plan
- Reset: assert Reset with RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF, ReadRegister1=5 -> ReadData1=0, WriteCount=0 throughout; after release, no register holds 0xDEADBEEF.
- Basic write/read: write 0x12345678 to r7 with BYPASS=0, ReadRegister1=7 -> ReadData1 shows the old value 0 in the write cycle and 0x12345678 the next cycle; WriteCount=1.
- Zero register: write 0xFFFFFFFF to r0 -> ReadData1/ReadData2 with address 0 read 0 before and after the edge; WriteCount unchanged.
- Bypass: BYPASS=1, RegWrite=1, WriteRegister=ReadRegister1=ReadRegister2=9, WriteData=0xA5A5A5A5 -> both ports read 0xA5A5A5A5 in the same cycle; same case with WriteRegister=0 -> both ports read 0.
- Decoder isolation: write a distinct value (r << 8 | r) to each of r1..r31, then read every register through both ports -> each returns its own value; WriteCount=31.
- Counter wrap and async reset: perform 256 writes to r3 -> WriteCount=0; assert Reset between clock edges -> registers and WriteCount read 0 before the next edge.
